hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 16-bit five-stage core.
- Drives the pause inputs of the PC, IF/ID and ID/EX pipeline registers. ID/EX treats its pause as "insert bubble" (zero operands, ALU/MEM NOP, no write-back).
- Detects load-use data hazards and instruction-memory write-recovery structural hazards.
- Keeps a saturating stall-cycle counter for debug.

---
 rtl/hazard_ctrl.sv | 92 +++++++++
 tb/tb_hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, instruction-RAM write recovery
// and a saturating debug counter of PC stall cycles.
module hazard_ctrl #(
  parameter int unsigned RECOVER_CYCLES = 2,  // 1..7
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_readReg1_i,
  input  logic [3:0]       id_readAddr1_i,
  input  logic             id_readReg2_i,
  input  logic [3:0]       id_readAddr2_i,
  input  logic [1:0]       ex_memOp_i,
  input  logic             ex_writeReg_i,
  input  logic [3:0]       ex_writeRegAddr_i,
  input  logic [1:0]       mem_memOp_i,
  input  logic             mem_imem_i,
  output logic             pc_pause_o,
  output logic             if_id_pause_o,
  output logic             if_id_bubble_o,
  output logic             id_ex_pause_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    ST_RUN,
    ST_RECOVER
  } state_e;

  localparam logic [1:0] MEMOP_READ  = 2'b01;
  localparam logic [1:0] MEMOP_WRITE = 2'b10;
  localparam logic [2:0] RCNT_LOAD   = 3'(RECOVER_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       rcnt_q, rcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             imem_wr;
  logic             recovering;

  // The EX-stage load's data is not ready until after MEM, so any ID reader stalls.
  assign lu = (ex_memOp_i == MEMOP_READ) && ex_writeReg_i &&
              ((id_readReg1_i && (id_readAddr1_i == ex_writeRegAddr_i)) ||
               (id_readReg2_i && (id_readAddr2_i == ex_writeRegAddr_i)));

  assign imem_wr    = (mem_memOp_i == MEMOP_WRITE) && mem_imem_i;
  assign recovering = (state_q == ST_RECOVER);

  assign pc_pause_o     = !rst && (lu || recovering);
  assign if_id_pause_o  = !rst && lu;
  assign if_id_bubble_o = !rst && recovering && !lu;
  assign id_ex_pause_o  = !rst && lu;
  assign stall_cnt_o    = stall_cnt_q;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (state_q == ST_RUN) begin
      if (imem_wr) begin
        state_d = ST_RECOVER;
        rcnt_d  = RCNT_LOAD;
      end
    end else begin
      // A fresh write restarts the full recovery window.
      if (imem_wr) begin
        rcnt_d = RCNT_LOAD;
      end else if (rcnt_q == 3'd0) begin
        state_d = ST_RUN;
      end else begin
        rcnt_d = rcnt_q - 3'd1;
      end
    end
  end

  assign stall_cnt_d = (pc_pause_o && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                           : stall_cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so all state updates together.
    if (rst) begin
      state_q     <= ST_RUN;
      rcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// compared each cycle against a remaining-cycles model of the fetch block.
module tb_hazard_ctrl;

  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd1, rd2, ex_wr, imem;
  logic [3:0] a1, a2, wa;
  logic [1:0] ex_op, mem_op;

  logic        pc_p, ifid_p, ifid_b, idex_p;
  logic        pc_p4, ifid_p4, ifid_b4, idex_p4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: cycles of fetch block still owed, and expected stall counts.
  int rem   = 0;
  int m_c16 = 0;
  int m_c4  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RECOVER_CYCLES(R), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_readReg1_i(rd1), .id_readAddr1_i(a1),
    .id_readReg2_i(rd2), .id_readAddr2_i(a2),
    .ex_memOp_i(ex_op), .ex_writeReg_i(ex_wr), .ex_writeRegAddr_i(wa),
    .mem_memOp_i(mem_op), .mem_imem_i(imem),
    .pc_pause_o(pc_p), .if_id_pause_o(ifid_p), .if_id_bubble_o(ifid_b),
    .id_ex_pause_o(idex_p), .stall_cnt_o(cnt16)
  );

  hazard_ctrl #(.RECOVER_CYCLES(R), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .id_readReg1_i(rd1), .id_readAddr1_i(a1),
    .id_readReg2_i(rd2), .id_readAddr2_i(a2),
    .ex_memOp_i(ex_op), .ex_writeReg_i(ex_wr), .ex_writeRegAddr_i(wa),
    .mem_memOp_i(mem_op), .mem_imem_i(imem),
    .pc_pause_o(pc_p4), .if_id_pause_o(ifid_p4), .if_id_bubble_o(ifid_b4),
    .id_ex_pause_o(idex_p4), .stall_cnt_o(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic idle();
    rst = 1'b0; rd1 = 1'b0; rd2 = 1'b0; a1 = 4'd0; a2 = 4'd0;
    ex_op = 2'b00; ex_wr = 1'b0; wa = 4'd0; mem_op = 2'b00; imem = 1'b0;
  endtask

  // Check this cycle's outputs at the negedge, then advance the model across the posedge.
  task automatic step();
    bit lu, blk, e_pc, e_ifp, e_bub, e_idex;
    @(negedge clk);
    lu  = (ex_op == 2'b01) && ex_wr && ((rd1 && a1 == wa) || (rd2 && a2 == wa));
    blk = (rem > 0);
    e_pc   = !rst && (lu || blk);
    e_ifp  = !rst && lu;
    e_bub  = !rst && blk && !lu;
    e_idex = !rst && lu;
    check("pc_pause",     pc_p,    e_pc);
    check("if_id_pause",  ifid_p,  e_ifp);
    check("if_id_bubble", ifid_b,  e_bub);
    check("id_ex_pause",  idex_p,  e_idex);
    check("pc_pause_w4",  pc_p4,   e_pc);
    check("bubble_w4",    ifid_b4, e_bub);
    check("stall_cnt16",  cnt16,   m_c16);
    check("stall_cnt4",   cnt4,    m_c4);
    @(posedge clk);
    if (rst) begin
      rem = 0; m_c16 = 0; m_c4 = 0;
    end else begin
      if (e_pc && m_c16 < 65535) m_c16++;
      if (e_pc && m_c4 < 15)     m_c4++;
      if (mem_op == 2'b10 && imem) rem = R;
      else if (rem > 0)            rem--;
    end
    #1;
  endtask

  task automatic set_lu_hit();
    ex_op = 2'b01; ex_wr = 1'b1; wa = 4'd3; rd2 = 1'b1; a2 = 4'd3;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset while recovering with a load-use pending.
    idle(); mem_op = 2'b10; imem = 1'b1; step();
    idle(); set_lu_hit(); mem_op = 2'b10; imem = 1'b1; rst = 1'b1; step(); step();
    idle(); step();

    // Load-use hit, then the three miss flavours.
    idle(); set_lu_hit(); step();
    idle(); set_lu_hit(); ex_op = 2'b10; step();
    idle(); set_lu_hit(); a2 = 4'd4; step();
    idle(); set_lu_hit(); rd2 = 1'b0; step();
    idle(); ex_op = 2'b01; ex_wr = 1'b1; wa = 4'd0; rd1 = 1'b1; a1 = 4'd0; step();

    // Imem recovery: write at t, blocked t+1..t+2, free at t+3.
    idle(); mem_op = 2'b10; imem = 1'b1; step();
    idle(); step(); step(); step();

    // Retrigger at t+1 and load-use overlap at t+2.
    idle(); mem_op = 2'b10; imem = 1'b1; step();
    idle(); mem_op = 2'b10; imem = 1'b1; step();
    idle(); set_lu_hit(); step();
    idle(); step(); step(); step();

    // Non-imem write and reserved memOp do not trigger recovery.
    idle(); mem_op = 2'b10; step();
    idle(); mem_op = 2'b11; imem = 1'b1; step();
    idle(); step();

    // Saturation of the 4-bit counter.
    idle(); set_lu_hit();
    for (int i = 0; i < 20; i++) step();
    idle(); step();

    // Random traffic with a narrow address space so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      rd1    = 1'($urandom);
      rd2    = 1'($urandom);
      a1     = 4'($urandom_range(0, 3));
      a2     = 4'($urandom_range(0, 3));
      wa     = 4'($urandom_range(0, 3));
      ex_op  = 2'($urandom);
      ex_wr  = 1'($urandom);
      mem_op = 2'($urandom);
      imem   = ($urandom_range(0, 3) == 0);
      step();
    end

    idle(); step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
